// File: rtl/arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package arb_pkg;

  localparam int unsigned DataW = 64;
  localparam int unsigned StrbW = DataW / 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  typedef enum logic {
    OwnIfu,
    OwnLsu
  } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between IFU and LSU requests.
// ARB_RR_EN selects round-robin on contention; otherwise the LSU always wins.
module arb_pick (
`ifdef ARB_RR_EN
  input  logic last_lsu,
`endif
  input  logic ireq_valid,
  input  logic dreq_valid,
  output logic grant_ifu,
  output logic grant_lsu
);

  always_comb begin
    grant_ifu = ireq_valid & ~dreq_valid;
    grant_lsu = dreq_valid & ~ireq_valid;
    if (ireq_valid && dreq_valid) begin
`ifdef ARB_RR_EN
      // Hand the port to whoever did not win the previous accept.
      grant_ifu = last_lsu;
      grant_lsu = ~last_lsu;
`else
      grant_lsu = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one request at a time.
// Define ARB_RR_EN for round-robin contention handling instead of fixed LSU priority.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = DataW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ireq_valid,
  input  logic [ADDR_W-1:0]     ireq_addr,
  output logic                  ireq_ready,
  output logic                  iresp_valid,
  output logic [31:0]           iresp_data,
  input  logic                  dreq_valid,
  input  logic [ADDR_W-1:0]     dreq_addr,
  input  logic                  dreq_we,
  input  logic [DATA_W-1:0]     dreq_wdata,
  input  logic [DATA_W/8-1:0]   dreq_wstrb,
  output logic                  dreq_ready,
  output logic                  dresp_valid,
  output logic [DATA_W-1:0]     dresp_rdata,
  output logic                  mreq_valid,
  output logic [ADDR_W-1:0]     mreq_addr,
  output logic                  mreq_we,
  output logic [DATA_W-1:0]     mreq_wdata,
  output logic [DATA_W/8-1:0]   mreq_wstrb,
  input  logic                  mreq_ready,
  input  logic                  mresp_valid,
  input  logic [DATA_W-1:0]     mresp_rdata,
  output logic                  busy
);

  state_e state_q;
  owner_e owner_q;
  logic   grant_ifu, grant_lsu;

`ifdef ARB_RR_EN
  owner_e last_q;
`endif

  arb_pick u_pick (
`ifdef ARB_RR_EN
    .last_lsu   (last_q == OwnLsu),
`endif
    .ireq_valid (ireq_valid),
    .dreq_valid (dreq_valid),
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu)
  );

  assign ireq_ready = (state_q == StIdle) & grant_ifu;
  assign dreq_ready = (state_q == StIdle) & grant_lsu;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIfu;
`ifdef ARB_RR_EN
      last_q      <= OwnIfu;
`endif
      mreq_valid  <= 1'b0;
      mreq_addr   <= '0;
      mreq_we     <= 1'b0;
      mreq_wdata  <= '0;
      mreq_wstrb  <= '0;
      iresp_valid <= 1'b0;
      iresp_data  <= '0;
      dresp_valid <= 1'b0;
      dresp_rdata <= '0;
    end else begin
      iresp_valid <= 1'b0;
      dresp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_lsu) begin
            mreq_addr  <= dreq_addr;
            mreq_we    <= dreq_we;
            mreq_wdata <= dreq_wdata;
            mreq_wstrb <= dreq_wstrb;
            owner_q    <= OwnLsu;
`ifdef ARB_RR_EN
            last_q     <= OwnLsu;
`endif
            mreq_valid <= 1'b1;
            state_q    <= StReq;
          end else if (grant_ifu) begin
            mreq_addr  <= ireq_addr;
            mreq_we    <= 1'b0;
            mreq_wdata <= '0;
            mreq_wstrb <= '0;
            owner_q    <= OwnIfu;
`ifdef ARB_RR_EN
            last_q     <= OwnIfu;
`endif
            mreq_valid <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (mreq_ready) begin
            mreq_valid <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (mresp_valid) begin
            if (owner_q == OwnLsu) begin
              dresp_valid <= 1'b1;
              dresp_rdata <= mresp_rdata;
            end else begin
              iresp_valid <= 1'b1;
              // Pick the 32-bit instruction word within the 64-bit beat.
              iresp_data  <= mreq_addr[2] ? mresp_rdata[63:32] : mresp_rdata[31:0];
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; stimulus driven on the falling edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic        dreq_we;
  logic [63:0] dreq_wdata;
  logic [7:0]  dreq_wstrb;
  logic        dreq_ready;
  logic        dresp_valid;
  logic [63:0] dresp_rdata;
  logic        mreq_valid;
  logic [63:0] mreq_addr;
  logic        mreq_we;
  logic [63:0] mreq_wdata;
  logic [7:0]  mreq_wstrb;
  logic        mreq_ready;
  logic        mresp_valid;
  logic [63:0] mresp_rdata;
  logic        busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .ireq_valid  (ireq_valid),
    .ireq_addr   (ireq_addr),
    .ireq_ready  (ireq_ready),
    .iresp_valid (iresp_valid),
    .iresp_data  (iresp_data),
    .dreq_valid  (dreq_valid),
    .dreq_addr   (dreq_addr),
    .dreq_we     (dreq_we),
    .dreq_wdata  (dreq_wdata),
    .dreq_wstrb  (dreq_wstrb),
    .dreq_ready  (dreq_ready),
    .dresp_valid (dresp_valid),
    .dresp_rdata (dresp_rdata),
    .mreq_valid  (mreq_valid),
    .mreq_addr   (mreq_addr),
    .mreq_we     (mreq_we),
    .mreq_wdata  (mreq_wdata),
    .mreq_wstrb  (mreq_wstrb),
    .mreq_ready  (mreq_ready),
    .mresp_valid (mresp_valid),
    .mresp_rdata (mresp_rdata),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Accept edge, one-cycle memory handshake, one-cycle response.
  task automatic run_txn(input logic [63:0] rdata);
    tick();
    mreq_ready = 1'b1;
    tick();
    mreq_ready  = 1'b0;
    mresp_valid = 1'b1;
    mresp_rdata = rdata;
    tick();
    mresp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({busy, mreq_valid, ireq_ready, dreq_ready, iresp_valid, dresp_valid} !== 6'b0)
      $display("FAIL reset_ctl got %b want 000000",
               {busy, mreq_valid, ireq_ready, dreq_ready, iresp_valid, dresp_valid});
    else passed++;
    checks++;
    if ({mreq_addr, mreq_we, mreq_wdata, mreq_wstrb, iresp_data, dresp_rdata} !== '0)
      $display("FAIL reset_data got addr=%h we=%b wdata=%h wstrb=%h idata=%h rdata=%h want 0",
               mreq_addr, mreq_we, mreq_wdata, mreq_wstrb, iresp_data, dresp_rdata);
    else passed++;
  endtask

  task automatic test_single_fetch();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0004;
    #1;
    checks++;
    if ({ireq_ready, dreq_ready} !== 2'b10)
      $display("FAIL fetch_ready got %b want 10", {ireq_ready, dreq_ready});
    else passed++;
    tick();
    ireq_valid = 1'b0;
    checks++;
    if ({mreq_valid, busy, mreq_we, mreq_wstrb, mreq_addr} !== {3'b110, 8'h00, 64'h8000_0004})
      $display("FAIL fetch_mreq got v=%b busy=%b we=%b strb=%h addr=%h want 1 1 0 00 80000004",
               mreq_valid, busy, mreq_we, mreq_wstrb, mreq_addr);
    else passed++;
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    checks++;
    if ({mreq_valid, busy, iresp_valid} !== 3'b010)
      $display("FAIL fetch_wait got %b want 010", {mreq_valid, busy, iresp_valid});
    else passed++;
    mresp_valid = 1'b1;
    mresp_rdata = 64'h0050_0093_0000_0013;
    tick();
    mresp_valid = 1'b0;
    checks++;
    if ({iresp_valid, dresp_valid, busy, iresp_data} !== {3'b100, 32'h0050_0093})
      $display("FAIL fetch_resp got v=%b dv=%b busy=%b data=%h want 1 0 0 00500093",
               iresp_valid, dresp_valid, busy, iresp_data);
    else passed++;
    tick();
    checks++;
    if (iresp_valid !== 1'b0)
      $display("FAIL fetch_pulse got %b want 0", iresp_valid);
    else passed++;
  endtask

  task automatic test_store();
    dreq_valid = 1'b1;
    dreq_we    = 1'b1;
    dreq_addr  = 64'h0000_1000;
    dreq_wdata = 64'hDEAD_BEEF;
    dreq_wstrb = 8'h0F;
    #1;
    checks++;
    if ({ireq_ready, dreq_ready} !== 2'b01)
      $display("FAIL store_ready got %b want 01", {ireq_ready, dreq_ready});
    else passed++;
    tick();
    dreq_valid = 1'b0;
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({mreq_valid, mreq_we, mreq_addr, mreq_wdata, mreq_wstrb, ireq_ready}
          !== {2'b11, 64'h1000, 64'hDEAD_BEEF, 8'h0F, 1'b0})
        $display("FAIL store_hold[%0d] got v=%b we=%b a=%h d=%h s=%h ir=%b want 1 1 1000 deadbeef 0f 0",
                 i, mreq_valid, mreq_we, mreq_addr, mreq_wdata, mreq_wstrb, ireq_ready);
      else passed++;
      tick();
    end
    ireq_valid = 1'b0;
    mreq_ready = 1'b1;
    tick();
    mreq_ready  = 1'b0;
    mresp_valid = 1'b1;
    mresp_rdata = 64'h0;
    tick();
    mresp_valid = 1'b0;
    checks++;
    if ({dresp_valid, iresp_valid, busy} !== 3'b100)
      $display("FAIL store_resp got %b want 100", {dresp_valid, iresp_valid, busy});
    else passed++;
    dreq_we = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_ifu;
    do_reset();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0010;
    dreq_valid = 1'b1;
    dreq_we    = 1'b0;
    dreq_addr  = 64'h0000_2000;
    #1;
    checks++;
    if ({ireq_ready, dreq_ready} !== 2'b01)
      $display("FAIL contend1 got %b want 01", {ireq_ready, dreq_ready});
    else passed++;
    run_txn(64'h1234_5678_9ABC_DEF0);
`ifdef ARB_RR_EN
    exp_ifu = 1'b1;
`else
    exp_ifu = 1'b0;
`endif
    checks++;
    if ({dresp_valid, dresp_rdata, ireq_ready, dreq_ready}
        !== {1'b1, 64'h1234_5678_9ABC_DEF0, exp_ifu, ~exp_ifu})
      $display("FAIL contend2 got dv=%b rd=%h ir=%b dr=%b want 1 123456789abcdef0 %b %b",
               dresp_valid, dresp_rdata, ireq_ready, dreq_ready, exp_ifu, ~exp_ifu);
    else passed++;
    run_txn(64'h0);
    checks++;
    if ({ireq_ready, dreq_ready} !== 2'b01)
      $display("FAIL contend3 got %b want 01", {ireq_ready, dreq_ready});
    else passed++;
    run_txn(64'h0);
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    ireq_valid = 1'b1;
    ireq_addr  = 64'h8000_0000;
    run_txn(64'h1111_1111_2222_2222);
    ireq_addr = 64'h8000_000C;
    #1;
    checks++;
    if ({iresp_valid, iresp_data, ireq_ready} !== {1'b1, 32'h2222_2222, 1'b1})
      $display("FAIL b2b_resp got v=%b data=%h ready=%b want 1 22222222 1",
               iresp_valid, iresp_data, ireq_ready);
    else passed++;
    tick();
    ireq_valid = 1'b0;
    checks++;
    if ({mreq_valid, mreq_addr} !== {1'b1, 64'h8000_000C})
      $display("FAIL b2b_mreq got v=%b addr=%h want 1 8000000c", mreq_valid, mreq_addr);
    else passed++;
    mreq_ready = 1'b1;
    tick();
    mreq_ready  = 1'b0;
    mresp_valid = 1'b1;
    mresp_rdata = 64'hAAAA_AAAA_BBBB_BBBB;
    tick();
    mresp_valid = 1'b0;
    checks++;
    if ({iresp_valid, iresp_data} !== {1'b1, 32'hAAAA_AAAA})
      $display("FAIL b2b_hi got v=%b data=%h want 1 aaaaaaaa", iresp_valid, iresp_data);
    else passed++;
  endtask

  task automatic test_rst_mid();
    dreq_valid = 1'b1;
    dreq_addr  = 64'h0000_3000;
    dreq_we    = 1'b0;
    tick();
    dreq_valid = 1'b0;
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, mreq_valid, mreq_addr, dresp_valid} !== '0)
      $display("FAIL rstmid_state got busy=%b v=%b addr=%h dv=%b want 0 0 0 0",
               busy, mreq_valid, mreq_addr, dresp_valid);
    else passed++;
    mresp_valid = 1'b1;
    mresp_rdata = 64'h5555_5555_5555_5555;
    tick();
    mresp_valid = 1'b0;
    checks++;
    if ({dresp_valid, iresp_valid, busy, dresp_rdata, iresp_data} !== '0)
      $display("FAIL rstmid_late got dv=%b iv=%b busy=%b rd=%h id=%h want 0 0 0 0 0",
               dresp_valid, iresp_valid, busy, dresp_rdata, iresp_data);
    else passed++;
  endtask

  task automatic test_spurious();
    mresp_valid = 1'b1;
    mreq_ready  = 1'b1;
    mresp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    mresp_valid = 1'b0;
    mreq_ready  = 1'b0;
    checks++;
    if ({iresp_valid, dresp_valid, busy, mreq_valid} !== 4'b0)
      $display("FAIL spurious got %b want 0000", {iresp_valid, dresp_valid, busy, mreq_valid});
    else passed++;
  endtask

  initial begin
    rst         = 1'b1;
    ireq_valid  = 1'b0;
    ireq_addr   = '0;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_we     = 1'b0;
    dreq_wdata  = '0;
    dreq_wstrb  = '0;
    mreq_ready  = 1'b0;
    mresp_valid = 1'b0;
    mresp_rdata = '0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_back_to_back();
    test_rst_mid();
    test_spurious();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
